// File: rtl/div_issue_queue_pkg.sv
// Shared types for the divider issue path: uop and branch-resolution records,
// divide opcodes, and the sequence-number age compare.
package div_issue_queue_pkg;

    localparam int SQN_W  = 7;
    localparam int XLEN   = 32;
    localparam int TAG_W  = 7;

    typedef logic [SQN_W-1:0] sqn_t;

    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_REM  = 2'd2,
        DIV_REMU = 2'd3
    } div_op_e;

    typedef struct packed {
        logic [XLEN-1:0]  srcA;
        logic [XLEN-1:0]  srcB;
        logic [TAG_W-1:0] tagDst;
        sqn_t             sqN;
        div_op_e          opcode;
        logic             valid;
    } EX_UOp;

    typedef struct packed {
        logic taken;
        sqn_t sqN;
    } BranchProv;

    // a is strictly younger than b under wrapping sequence numbers:
    // the difference a-b, read as signed, is positive.
    function automatic logic is_younger(input sqn_t a, input sqn_t b);
        sqn_t diff;
        diff = a - b;
        return (diff != '0) && !diff[SQN_W-1];
    endfunction

    function automatic logic is_flushed(input BranchProv br, input sqn_t s);
        return br.taken && is_younger(s, br.sqN);
    endfunction

endpackage

// File: rtl/div_issue_queue.sv
// Age-ordered queue in front of the iterative divider: holds DIV/REM uops,
// issues one registered uop at a time and drops entries squashed by a branch.
module div_issue_queue
    import div_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  BranchProv IN_branch,
    input  EX_UOp     IN_uop,
    output logic      OUT_full,
    input  logic      IN_divBusy,
    input  logic      IN_resValid,
    output logic      OUT_en,
    output EX_UOp     OUT_uop
);

    localparam int IDX_W = $clog2(DEPTH);
    typedef logic [IDX_W:0] ptr_t;

    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    EX_UOp            entries_q [DEPTH];
    EX_UOp            out_uop_q, out_uop_d;
    logic             out_en_q, out_en_d;
    logic             inflight_q, inflight_d;
    sqn_t             inflight_sqn_q, inflight_sqn_d;

    logic [DEPTH-1:0] flush_vec;
    ptr_t             count;
    ptr_t             survivor_wr;
    ptr_t             scan_slot;
    logic             scan_found;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] enq_slot;
    logic             issue;
    logic             enq;

    assign count    = wr_ptr_q - rd_ptr_q;
    assign OUT_full = (count == ptr_t'(DEPTH));
    assign head_idx = rd_ptr_q[IDX_W-1:0];

    for (genvar i = 0; i < DEPTH; i++) begin : g_flush
        assign flush_vec[i] = valid_q[i] && is_flushed(IN_branch, entries_q[i].sqN);
    end

    // Entries are in program order, so a flush removes a contiguous suffix:
    // the first flushed slot from the head becomes the new write pointer.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        survivor_wr = wr_ptr_q;
        scan_slot   = rd_ptr_q;
        scan_found  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_slot = rd_ptr_q + ptr_t'(k);
            if (!scan_found && (ptr_t'(k) < count) && flush_vec[scan_slot[IDX_W-1:0]]) begin
                survivor_wr = scan_slot;
                scan_found  = 1'b1;
            end
        end
    end

    assign enq_slot = survivor_wr[IDX_W-1:0];
    assign issue    = valid_q[head_idx] && !flush_vec[head_idx] && !inflight_q
                      && !IN_divBusy && !out_uop_q.valid;
    assign enq      = IN_uop.valid && !OUT_full && !is_flushed(IN_branch, IN_uop.sqN);

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = survivor_wr;
        valid_d   = valid_q & ~flush_vec;
        out_uop_d = out_uop_q;
        out_uop_d.valid = 1'b0;
        out_en_d  = 1'b0;

        if (issue) begin
            rd_ptr_d          = rd_ptr_q + ptr_t'(1);
            valid_d[head_idx] = 1'b0;
            out_uop_d         = entries_q[head_idx];
            out_uop_d.valid   = 1'b1;
            out_en_d          = 1'b1;
        end
        if (enq) begin
            valid_d[enq_slot] = 1'b1;
            wr_ptr_d          = survivor_wr + ptr_t'(1);
        end
    end

    // Clear first, then set: a freshly presented unflushed uop wins over a
    // clear, which can only refer to the previous one.
    always_comb begin
        inflight_d     = inflight_q;
        inflight_sqn_d = inflight_sqn_q;
        if (IN_resValid || (inflight_q && is_flushed(IN_branch, inflight_sqn_q))) begin
            inflight_d = 1'b0;
        end
        if (out_uop_q.valid && !is_flushed(IN_branch, out_uop_q.sqN)) begin
            inflight_d     = 1'b1;
            inflight_sqn_d = out_uop_q.sqN;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            valid_q        <= '0;
            out_uop_q      <= '0;
            out_en_q       <= 1'b0;
            inflight_q     <= 1'b0;
            inflight_sqn_q <= '0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            valid_q        <= valid_d;
            out_uop_q      <= out_uop_d;
            out_en_q       <= out_en_d;
            inflight_q     <= inflight_d;
            inflight_sqn_q <= inflight_sqn_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; the valid bits gate every read.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries_q[enq_slot] <= IN_uop;
        end
    end

    assign OUT_en  = out_en_q;
    assign OUT_uop = out_uop_q;

endmodule

// File: tb/tb_div_issue_queue.sv
// Directed bench for div_issue_queue: hand-computed issue order, timing,
// full flag, flush and reset behaviour; the divider is modelled by hand.
module tb_div_issue_queue;
    import div_issue_queue_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    BranchProv branch;
    EX_UOp     uop_in;
    logic      full;
    logic      div_busy;
    logic      res_valid;
    logic      out_en;
    EX_UOp     out_uop;

    int n_vec = 0;
    int n_err = 0;

    div_issue_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .IN_branch  (branch),
        .IN_uop     (uop_in),
        .OUT_full   (full),
        .IN_divBusy (div_busy),
        .IN_resValid(res_valid),
        .OUT_en     (out_en),
        .OUT_uop    (out_uop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic EX_UOp mk(input int sqn, input div_op_e op, input int a, input int b);
        EX_UOp u;
        u.valid  = 1'b1;
        u.opcode = op;
        u.sqN    = sqn_t'(sqn);
        u.tagDst = TAG_W'(sqn);
        u.srcA   = a;
        u.srcB   = b;
        return u;
    endfunction

    task automatic enqueue(input int sqn);
        uop_in = mk(sqn, DIV_DIVU, sqn * 3, 2);
        step();
        uop_in.valid = 1'b0;
    endtask

    // Waits a bounded number of cycles for OUT_en, checks the uop, then
    // checks the enable is exactly one cycle wide.
    task automatic wait_issue(input string tag, input int sqn);
        int cyc;
        cyc = 0;
        while (!out_en && cyc < 20) begin
            step();
            cyc++;
        end
        check({tag, "_en"}, 32'(out_en), 1);
        check({tag, "_sqn"}, 32'(out_uop.sqN), sqn);
        step();
        check({tag, "_pulse"}, 32'(out_en), 0);
    endtask

    task automatic ack();
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        branch    = '0;
        uop_in    = '0;
        div_busy  = 1'b0;
        res_valid = 1'b0;
        step();
        step();
        check("rst_en", 32'(out_en), 0);
        check("rst_valid", 32'(out_uop.valid), 0);
        check("rst_full", 32'(full), 0);
        rst = 1'b0;

        // 1: single DIV, two-cycle latency, one-cycle enable
        uop_in = mk(5, DIV_DIV, 100, 7);
        step();
        uop_in.valid = 1'b0;
        check("t1_nobypass", 32'(out_en), 0);
        step();
        check("t1_en", 32'(out_en), 1);
        check("t1_sqn", 32'(out_uop.sqN), 5);
        check("t1_srcA", out_uop.srcA, 100);
        check("t1_srcB", out_uop.srcB, 7);
        check("t1_op", 32'(out_uop.opcode), 32'(DIV_DIV));
        step();
        check("t1_pulse_en", 32'(out_en), 0);
        check("t1_pulse_valid", 32'(out_uop.valid), 0);
        ack();

        // 2: fill while divider busy, then release
        div_busy = 1'b1;
        for (int s = 1; s <= 4; s++) enqueue(s);
        check("t2_full", 32'(full), 1);
        check("t2_noissue", 32'(out_en), 0);
        step();
        check("t2_noissue2", 32'(out_en), 0);
        div_busy  = 1'b0;
        res_valid = 1'b1;
        step();
        res_valid = 1'b0;
        check("t2_en", 32'(out_en), 1);
        check("t2_sqn", 32'(out_uop.sqN), 1);
        check("t2_notfull", 32'(full), 0);
        step();
        check("t2_pulse", 32'(out_en), 0);
        for (int s = 2; s <= 4; s++) begin
            ack();
            wait_issue("t2_drain", s);
        end
        ack();

        // 3: flush removes 12,13; same-cycle 14 dropped; count proven via full
        div_busy = 1'b1;
        for (int s = 10; s <= 13; s++) enqueue(s);
        check("t3_full", 32'(full), 1);
        branch.taken = 1'b1;
        branch.sqN   = sqn_t'(11);
        uop_in       = mk(14, DIV_REM, 1, 1);
        step();
        branch.taken = 1'b0;
        uop_in.valid = 1'b0;
        check("t3_after_flush", 32'(full), 0);
        enqueue(15);
        check("t3_three", 32'(full), 0);
        enqueue(16);
        check("t3_four", 32'(full), 1);
        div_busy = 1'b0;
        wait_issue("t3_a", 10);
        ack();
        wait_issue("t3_b", 11);
        ack();
        wait_issue("t3_c", 15);
        ack();
        wait_issue("t3_d", 16);
        ack();

        // 4: flush of the in-flight uop frees the divider path. The follow-up
        // uop is dispatched after the branch, since one queued before it
        // would be younger than sqN 19 and squashed too.
        enqueue(20);
        wait_issue("t4_a", 20);
        branch.taken = 1'b1;
        branch.sqN   = sqn_t'(19);
        step();
        branch.taken = 1'b0;
        enqueue(21);
        wait_issue("t4_b", 21);
        ack();

        // 5: enqueue on each issue cycle keeps count at DEPTH-1
        div_busy = 1'b1;
        for (int s = 30; s <= 32; s++) enqueue(s);
        check("t5_notfull", 32'(full), 0);
        div_busy = 1'b0;
        uop_in   = mk(33, DIV_REMU, 9, 4);
        step();
        uop_in.valid = 1'b0;
        check("t5_en0", 32'(out_en), 1);
        check("t5_sqn0", 32'(out_uop.sqN), 30);
        check("t5_full0", 32'(full), 0);
        step();
        for (int k = 0; k < 4; k++) begin
            ack();
            enqueue(34 + k);
            check("t5_en", 32'(out_en), 1);
            check("t5_sqn", 32'(out_uop.sqN), 31 + k);
            check("t5_full", 32'(full), 0);
            step();
            check("t5_pulse", 32'(out_en), 0);
        end
        for (int s = 35; s <= 37; s++) begin
            ack();
            wait_issue("t5_drain", s);
        end
        ack();

        // 6: reset mid-operation discards queue and inflight
        enqueue(40);
        wait_issue("t6_a", 40);
        for (int s = 41; s <= 43; s++) enqueue(s);
        check("t6_blocked", 32'(out_en), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_en", 32'(out_en), 0);
        check("t6_rst_valid", 32'(out_uop.valid), 0);
        check("t6_rst_full", 32'(full), 0);
        enqueue(50);
        wait_issue("t6_b", 50);
        ack();
        step();
        check("t6_idle", 32'(out_en), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
